// File: rtl/i_cache.sv
// i_cache: direct-mapped 4-line, 4-word instruction cache with zero-wait hits and a single outstanding line fill.
// reset_n is active-high despite its name.
module i_cache #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_readM,
    input  logic [WORD_SIZE-1:0]            i_address,
    output logic [WORD_SIZE-1:0]            i_data,
    output logic                            i_ready,
    input  logic                            flush,
    output logic                            mem_read,
    output logic [WORD_SIZE-1:0]            mem_address,
    input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_data,
    input  logic                            mem_valid,
    output logic [15:0]                     hit_count,
    output logic [15:0]                     miss_count
);
    localparam int TAG_W = WORD_SIZE - 4;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                            r_state, w_next;
    logic [NUM_LINES-1:0]              r_valid;
    logic [TAG_W-1:0]                  r_tag  [NUM_LINES];
    logic [WORD_SIZE*LINE_WORDS-1:0]   r_line [NUM_LINES];
    logic [WORD_SIZE-1:0]              r_fill_addr;
    logic [1:0]                        w_index, w_offset, w_fill_index;
    logic [TAG_W-1:0]                  w_tag;
    logic                              w_hit, w_miss, w_fill_done;

    assign w_index      = i_address[3:2];
    assign w_offset     = i_address[1:0];
    assign w_tag        = i_address[WORD_SIZE-1:4];
    assign w_fill_index = r_fill_addr[3:2];
    assign w_hit        = i_readM & (r_state == IDLE) & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign i_ready      = w_hit & ~flush & ~reset_n;
    assign i_data       = r_line[w_index][{w_offset, 4'b0000} +: WORD_SIZE];
    assign mem_read     = (r_state == FILL);
    assign mem_address  = r_fill_addr;

    always_comb begin
        w_next      = r_state;
        w_miss      = 1'b0;
        w_fill_done = 1'b0;
        if (r_state == IDLE) begin
            w_miss = i_readM & ~w_hit & ~flush;
            w_next = w_miss ? FILL : IDLE;
        end else begin
            w_fill_done = mem_valid & ~flush;
            w_next      = (flush | mem_valid) ? IDLE : FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            r_state <= w_next;
            if (flush)
                r_valid <= '0;
            else if (w_fill_done)
                r_valid[w_fill_index] <= 1'b1;
            if (i_ready)
                hit_count <= hit_count + 16'd1;
            if (w_miss)
                miss_count <= miss_count + 16'd1;
        end
    end

    // Tag/data storage and fill address carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (w_miss)
            r_fill_addr <= {i_address[WORD_SIZE-1:2], 2'b00};
        if (w_fill_done) begin
            r_tag[w_fill_index]  <= r_fill_addr[WORD_SIZE-1:4];
            r_line[w_fill_index] <= mem_data;
        end
    end
endmodule

// File: tb/tb_i_cache.sv
// tb_i_cache: randomized scoreboard bench for i_cache against a resident-line reference model.
module tb_i_cache;
    logic        clk = 0, reset_n = 1, i_readM = 0, flush = 0, mem_valid = 0;
    logic [15:0] i_address = 0;
    logic [63:0] mem_data = 0;
    logic [15:0] i_data, mem_address, hit_count, miss_count;
    logic        i_ready, mem_read;

    logic [15:0] mem [65536];
    logic [15:0] exp_q [$];
    logic [13:0] res_line [4];
    bit          res_v [4];
    logic [15:0] exp_hits = 0, exp_misses = 0;
    int          vectors = 0, errors = 0, lat = 3;

    i_cache dut (
        .clk(clk), .reset_n(reset_n), .i_readM(i_readM), .i_address(i_address),
        .i_data(i_data), .i_ready(i_ready), .flush(flush), .mem_read(mem_read),
        .mem_address(mem_address), .mem_data(mem_data), .mem_valid(mem_valid),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] line_of(input logic [15:0] a);
        logic [15:0] b;
        b = {a[15:2], 2'b00};
        return {mem[b + 16'd3], mem[b + 16'd2], mem[b + 16'd1], mem[b]};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) res_v[i] = 0;
    endtask

    // Scoreboard monitor: every cycle the DUT claims a completed fetch, pop and compare.
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (i_ready === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: addr %h data %h with no fetch outstanding", i_address, i_data);
                end else begin
                    e = exp_q.pop_front();
                    if (i_data !== e) begin
                        errors++;
                        $display("FAIL fetch_data: addr %h got %h expected %h", i_address, i_data, e);
                    end
                end
            end
        end
    end

    // Waits for i_ready while acting as the memory (fill returned after lat cycles of mem_read).
    task automatic wait_ready(input logic [15:0] a, input int exp_n);
        int n, cnt;
        bit got;
        n = 0; cnt = 0; got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2 && exp_n > 1) begin
                chk("mem_read_in_fill", 16'(mem_read), 16'd1);
                chk("mem_address", mem_address, {a[15:2], 2'b00});
            end
            if (i_ready) got = 1;
            else if (mem_read) begin
                cnt++;
                if (cnt == lat) begin
                    mem_data  = line_of(mem_address);
                    mem_valid = 1;
                end
            end
            if (!got) begin
                @(posedge clk);
                #1 mem_valid = 0;
            end
        end
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL fetch_timeout: addr %h got no i_ready required within 40 cycles", a);
        end else if (exp_n > 0)
            chk("fetch_latency", 16'(n), 16'(exp_n));
    endtask

    task automatic fetch(input logic [15:0] a);
        bit hit;
        hit = res_v[a[3:2]] && res_line[a[3:2]] == a[15:2];
        @(posedge clk);
        #1 i_readM = 1;
        i_address = a;
        exp_q.push_back(mem[a]);
        wait_ready(a, hit ? 1 : lat + 2);
        if (!hit) begin
            exp_misses++;
            res_v[a[3:2]]    = 1;
            res_line[a[3:2]] = a[15:2];
        end
        exp_hits++;
    endtask

    task automatic chk_cnt();
        @(posedge clk);
        #1 i_readM = 0;
        @(negedge clk);
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h10] = 16'h1111; mem[16'h11] = 16'h2222;
        mem[16'h12] = 16'h3333; mem[16'h13] = 16'h4444;
        clear_model();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_i_ready", 16'(i_ready), 16'd0);
        chk("reset_mem_read", 16'(mem_read), 16'd0);
        chk("reset_hit_count", hit_count, 16'd0);
        chk("reset_miss_count", miss_count, 16'd0);
        @(posedge clk);
        #1 reset_n = 0;

        lat = 3;
        fetch(16'h0012);
        chk_cnt();
        fetch(16'h0010); fetch(16'h0011); fetch(16'h0013);
        chk_cnt();
        fetch(16'h0052); fetch(16'h0012);
        chk_cnt();

        // Flush coinciding with a would-be hit.
        @(posedge clk);
        #1 i_readM = 1; i_address = 16'h0012; flush = 1;
        @(negedge clk);
        chk("flush_blocks_hit", 16'(i_ready), 16'd0);
        @(posedge clk);
        #1 flush = 0; i_readM = 0;
        clear_model();
        fetch(16'h0012);
        chk_cnt();

        // Flush one cycle before mem_valid.
        @(posedge clk);
        #1 i_readM = 1; i_address = 16'h0020;
        @(negedge clk);
        chk("fm_miss_ready", 16'(i_ready), 16'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("fm_mem_read", 16'(mem_read), 16'd1);
        chk("fm_mem_address", mem_address, 16'h0020);
        @(posedge clk);
        #1 flush = 1;
        @(negedge clk);
        chk("fm_flush_ready", 16'(i_ready), 16'd0);
        @(posedge clk);
        #1 flush = 0; mem_valid = 1; mem_data = line_of(16'h0020);
        @(negedge clk);
        chk("fm_idle_ready", 16'(i_ready), 16'd0);
        chk("fm_idle_mem_read", 16'(mem_read), 16'd0);
        @(posedge clk);
        #1 mem_valid = 0;
        clear_model();
        exp_misses += 16'd2;
        @(negedge clk);
        chk("fm_rereq_mem_read", 16'(mem_read), 16'd1);
        chk("fm_rereq_address", mem_address, 16'h0020);
        exp_q.push_back(mem[16'h0020]);
        wait_ready(16'h0020, -1);
        res_v[0] = 1; res_line[0] = 14'h0008;
        exp_hits++;
        chk_cnt();

        // Reset during a fill, then a stale mem_valid.
        @(posedge clk);
        #1 i_readM = 1; i_address = 16'h0030;
        @(negedge clk);
        chk("rm_miss_ready", 16'(i_ready), 16'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rm_mem_read", 16'(mem_read), 16'd1);
        @(posedge clk);
        #1 reset_n = 1; i_readM = 0;
        @(posedge clk);
        #1 reset_n = 0; mem_valid = 1; mem_data = line_of(16'h0030);
        @(negedge clk);
        chk("rm_mem_read_low", 16'(mem_read), 16'd0);
        chk("rm_hit_count", hit_count, 16'd0);
        chk("rm_miss_count", miss_count, 16'd0);
        @(posedge clk);
        #1 mem_valid = 0;
        clear_model();
        exp_hits = 0; exp_misses = 0;
        fetch(16'h0030);
        chk_cnt();

        for (int k = 0; k < 400; k++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op == 0) begin
                @(posedge clk);
                #1 i_readM = 0; flush = 1;
                @(posedge clk);
                #1 flush = 0;
                clear_model();
            end else if (op == 1) begin
                @(posedge clk);
                #1 i_readM = 0; mem_valid = 1; mem_data = {$urandom, $urandom};
                @(posedge clk);
                #1 mem_valid = 0;
            end else if (op == 2) begin
                @(posedge clk);
                #1 i_readM = 0;
            end else begin
                lat = $urandom_range(1, 5);
                fetch(($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63)));
            end
        end
        chk_cnt();

        // Counter wrap after 65536 hits.
        @(posedge clk);
        #1 i_readM = 0; reset_n = 1;
        @(posedge clk);
        #1 reset_n = 0;
        clear_model();
        exp_hits = 0; exp_misses = 0;
        lat = 1;
        repeat (65536) fetch(16'h0000);
        chk_cnt();
        chk("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
